mac_seq: RTL

Command-driven sequencer for the TinyTapeout MAC datapath. Accepts CLEAR / MAC / READ commands over a valid/ready handshake, drives the MAC's operand, enable and clear strobes, and streams the captured accumulator out as LSB-first bytes. Sits between the pin-level input decoder and the MAC core inside `tt_um_mac_test`.

---
 rtl/mac_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mac_seq.sv
// mac_seq: command sequencer driving the MAC core and streaming its accumulator out LSB-first.
// Define MAC_SEQ_CNT_EN to append a saturating MAC-op count byte to every READ burst.
module mac_seq #(
  parameter int ACC_W  = 20,
  parameter int NBYTES = (ACC_W + 7) / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  output logic             mac_en,
  output logic             mac_clr,
  input  logic [ACC_W-1:0] mac_acc,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  output logic             out_last
);

`ifdef MAC_SEQ_CNT_EN
  localparam int TOTAL = NBYTES + 1;
`else
  localparam int TOTAL = NBYTES;
`endif
  localparam int SH_W = 8 * TOTAL;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_MAC   = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SHIFT} state_t;

  state_t          state, state_d;
  logic [SH_W-1:0] sh, sh_d, sh_load;
  logic [3:0]      idx, idx_d;
  logic            ready_d, en_d, clr_d, valid_d, last_d;
  logic [7:0]      a_d, b_d, byte_d;
  logic            accept;

  assign accept = cmd_valid & cmd_ready & (state == IDLE);

`ifdef MAC_SEQ_CNT_EN
  logic [7:0] cnt, cnt_d;
  assign sh_load = {cnt, (8 * NBYTES)'(mac_acc)};
`else
  assign sh_load = SH_W'(mac_acc);
`endif

  // SHIFT spends one fill cycle before byte0 so that out_byte stays registered;
  // idx == TOTAL marks the cycle where the last byte drops and IDLE resumes.
  always_comb begin
    state_d = state;
    en_d    = 1'b0;
    clr_d   = 1'b0;
    a_d     = mac_a;
    b_d     = mac_b;
    byte_d  = out_byte;
    valid_d = 1'b0;
    last_d  = 1'b0;
    sh_d    = sh;
    idx_d   = idx;
`ifdef MAC_SEQ_CNT_EN
    cnt_d   = cnt;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_CLEAR: begin
              clr_d   = 1'b1;
              state_d = ISSUE;
`ifdef MAC_SEQ_CNT_EN
              cnt_d   = 8'd0;
`endif
            end
            OP_MAC: begin
              en_d    = 1'b1;
              a_d     = cmd_a;
              b_d     = cmd_b;
              state_d = ISSUE;
`ifdef MAC_SEQ_CNT_EN
              if (cnt != 8'hFF) cnt_d = cnt + 8'd1;
`endif
            end
            OP_READ: state_d = WAIT;
            default: state_d = ISSUE;
          endcase
        end
      end
      ISSUE: state_d = IDLE;
      WAIT: begin
        sh_d    = sh_load;
        idx_d   = 4'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (idx == 4'(TOTAL)) begin
          state_d = IDLE;
        end else begin
          valid_d = 1'b1;
          byte_d  = sh[7:0];
          sh_d    = sh >> 8;
          last_d  = (idx == 4'(TOTAL - 1));
          idx_d   = idx + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      mac_a     <= 8'd0;
      mac_b     <= 8'd0;
      out_byte  <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      sh        <= '0;
      idx       <= 4'd0;
`ifdef MAC_SEQ_CNT_EN
      cnt       <= 8'd0;
`endif
    end else begin
      state     <= state_d;
      cmd_ready <= ready_d;
      mac_en    <= en_d;
      mac_clr   <= clr_d;
      mac_a     <= a_d;
      mac_b     <= b_d;
      out_byte  <= byte_d;
      out_valid <= valid_d;
      out_last  <= last_d;
      sh        <= sh_d;
      idx       <= idx_d;
`ifdef MAC_SEQ_CNT_EN
      cnt       <= cnt_d;
`endif
    end
  end

endmodule
